// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state encoding and time conversion for the button event path
package button_pkg;

   typedef enum logic [1:0] {
      ST_RELEASED  = 2'd0,
      ST_HOLD_WAIT = 2'd1,
      ST_REPEATING = 2'd2
   } ev_state_t;

   function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
      return clk_hz / 1000 * ms;
   endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// rtl/btn_sync_debounce.sv - two-flop synchroniser plus stable-time debounce of an active-low pin
module btn_sync_debounce #(
   parameter int unsigned DB_CYC = 4
) (
   input  logic real_clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int DBW = $clog2(DB_CYC + 1);

   logic           s1;
   logic           s2;
   logic [DBW-1:0] db_cnt;

   always_ff @(posedge real_clk or posedge rst) begin
      if (rst) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         db_cnt <= '0;
         level  <= 1'b0;
      end else begin
         s1 <= ~raw;
         s2 <= s1;
         // Any cycle of agreement restarts the stable-time window.
         if (s2 == level) begin
            db_cnt <= '0;
         end else if (db_cnt == DBW'(DB_CYC - 1)) begin
            level  <= s2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/button_event_gen.sv
// rtl/button_event_gen.sv - debounced push-button to press/release/step pulses with hold-to-repeat
module button_event_gen
   import button_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 12_000_000,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned HOLD_MS     = 500,
   parameter int unsigned REPEAT_MS   = 100
) (
   input  logic real_clk,
   input  logic rst,
   input  logic btn_n,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic step_pulse,
   output logic repeat_active
);

   localparam int unsigned DB_CYC   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
   localparam int unsigned HOLD_CYC = ms_to_cycles(CLK_HZ, HOLD_MS);
   localparam int unsigned REP_CYC  = ms_to_cycles(CLK_HZ, REPEAT_MS);
   localparam int unsigned TMR_MAX  = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
   localparam int          TW       = $clog2(TMR_MAX + 1);

   ev_state_t       state, state_nx;
   logic [TW-1:0]   tmr, tmr_nx;
   logic            pressed_d;
   logic            press_nx, release_nx, step_nx, rep_nx;
   logic            rise, fall;

   btn_sync_debounce #(.DB_CYC(DB_CYC)) u_sync_debounce (
      .real_clk (real_clk),
      .rst      (rst),
      .raw      (btn_n),
      .level    (pressed)
   );

   assign rise = pressed & ~pressed_d;
   assign fall = ~pressed & pressed_d;

   always_ff @(posedge real_clk or posedge rst) begin
      if (rst) begin
         state         <= ST_RELEASED;
         tmr           <= '0;
         pressed_d     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         step_pulse    <= 1'b0;
         repeat_active <= 1'b0;
      end else begin
         state         <= state_nx;
         tmr           <= tmr_nx;
         pressed_d     <= pressed;
         press_pulse   <= press_nx;
         release_pulse <= release_nx;
         step_pulse    <= step_nx;
         repeat_active <= rep_nx;
      end
   end

   // Release is tested before timer expiry so it always wins a tie.
   always_comb begin
      state_nx   = state;
      tmr_nx     = tmr;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      step_nx    = 1'b0;
      case (state)
         ST_RELEASED: begin
            if (rise) begin
               press_nx = 1'b1;
               step_nx  = 1'b1;
               tmr_nx   = '0;
               state_nx = ST_HOLD_WAIT;
            end
         end
         ST_HOLD_WAIT: begin
            tmr_nx = tmr + 1'b1;
            if (fall) begin
               release_nx = 1'b1;
               state_nx   = ST_RELEASED;
            end else if (HOLD_MS != 0 && tmr == TW'(HOLD_CYC - 1)) begin
               step_nx  = 1'b1;
               tmr_nx   = '0;
               state_nx = ST_REPEATING;
            end
         end
         ST_REPEATING: begin
            tmr_nx = tmr + 1'b1;
            if (fall) begin
               release_nx = 1'b1;
               state_nx   = ST_RELEASED;
            end else if (tmr == TW'(REP_CYC - 1)) begin
               step_nx = 1'b1;
               tmr_nx  = '0;
            end
         end
         default: state_nx = ST_RELEASED;
      endcase
      rep_nx = (state_nx == ST_REPEATING);
   end

endmodule

// File: tb/tb_button_event_gen.sv
// tb/tb_button_event_gen.sv - self-checking bench for button_event_gen against a hold-duration model
module tb_button_event_gen;

   localparam int CLK_HZ      = 1000;
   localparam int DEBOUNCE_MS = 4;
   localparam int HOLD_MS     = 20;
   localparam int REPEAT_MS   = 5;
   localparam int DB_CYC      = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int HOLD_CYC    = CLK_HZ / 1000 * HOLD_MS;
   localparam int REP_CYC     = CLK_HZ / 1000 * REPEAT_MS;

   logic real_clk = 1'b0;
   logic rst      = 1'b1;
   logic btn_n    = 1'b1;
   logic pressed, press_pulse, release_pulse, step_pulse, repeat_active;

   button_event_gen #(
      .CLK_HZ      (CLK_HZ),
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .HOLD_MS     (HOLD_MS),
      .REPEAT_MS   (REPEAT_MS)
   ) dut (
      .real_clk      (real_clk),
      .rst           (rst),
      .btn_n         (btn_n),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .step_pulse    (step_pulse),
      .repeat_active (repeat_active)
   );

   always #5 real_clk = ~real_clk;

   int checks = 0;
   int passes = 0;
   int edge_cnt = 0;
   int t0 = 0;

   // Model state: pipeline samples, disagreement run length, hold duration in edges.
   int m_s1, m_s2, m_p, m_pd, m_run, m_held, m_rep, m_h;
   int e_press, e_rel, e_step;

   int press_log[$];
   int rel_log[$];
   int step_log[$];
   int pressed_first;
   int rep_first;

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_p = 0; m_pd = 0; m_run = 0;
      m_held = 0; m_rep = 0; m_h = 0;
      e_press = 0; e_rel = 0; e_step = 0;
   endtask

   task automatic model_edge();
      int p_old, pd_old, s2_old;
      p_old  = m_p;
      pd_old = m_pd;
      s2_old = m_s2;
      e_press = 0; e_rel = 0; e_step = 0;
      if (m_held == 0) begin
         if (p_old == 1 && pd_old == 0) begin
            e_press = 1; e_step = 1; m_held = 1; m_h = 0; m_rep = 0;
         end
      end else begin
         m_h = m_h + 1;
         if (p_old == 0 && pd_old == 1) begin
            e_rel = 1; m_held = 0; m_rep = 0;
         end else if (HOLD_MS != 0 && m_h == HOLD_CYC) begin
            e_step = 1; m_rep = 1;
         end else if (m_rep == 1 && m_h > HOLD_CYC && (m_h - HOLD_CYC) % REP_CYC == 0) begin
            e_step = 1;
         end
      end
      m_pd = p_old;
      if (s2_old != p_old) begin
         m_run = m_run + 1;
         if (m_run == DB_CYC) begin
            m_p = s2_old;
            m_run = 0;
         end
      end else begin
         m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_n ? 0 : 1;
      edge_cnt = edge_cnt + 1;
   endtask

   task automatic cmp(input string nm, input logic act, input int exp);
      checks++;
      if (act === exp[0]) passes++;
      else $display("FAIL %s at cycle %0d: got %0b, expected %0d", nm, edge_cnt - t0, act, exp);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge real_clk);
      #2;
   endtask

   task automatic start_scn();
      press_log.delete();
      rel_log.delete();
      step_log.delete();
      pressed_first = -1;
      rep_first = -1;
      t0 = edge_cnt;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge real_clk or posedge rst);
         if (rst) model_reset();
         else model_edge();
      end
   end

   initial begin
      int n;
      @(posedge real_clk);
      forever begin
         @(negedge real_clk);
         n = edge_cnt - t0;
         cmp("pressed", pressed, m_p);
         cmp("press_pulse", press_pulse, e_press);
         cmp("release_pulse", release_pulse, e_rel);
         cmp("step_pulse", step_pulse, e_step);
         cmp("repeat_active", repeat_active, m_rep);
         if (press_pulse) press_log.push_back(n);
         if (release_pulse) rel_log.push_back(n);
         if (step_pulse) step_log.push_back(n);
         if (pressed && pressed_first < 0) pressed_first = n;
         if (repeat_active && rep_first < 0) rep_first = n;
      end
   end

   initial begin
      int exp_steps[7];
      exp_steps = '{7, 27, 32, 37, 42, 47, 52};

      // Reset held while the pin toggles, then idle released.
      start_scn();
      for (int i = 0; i < 8; i++) begin
         tick(1);
         btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      end
      btn_n = 1'b1;
      rst = 1'b0;
      tick(12);
      chk("reset_no_press", press_log.size(), 0);
      chk("reset_no_step", step_log.size(), 0);
      chk("reset_pressed", pressed_first, -1);

      // Clean press then release.
      start_scn();
      btn_n = 1'b0;
      tick(12);
      chk("clean_pressed_cycle", pressed_first, 6);
      chk("clean_press_count", press_log.size(), 1);
      if (press_log.size() > 0) chk("clean_press_cycle", press_log[0], 7);
      chk("clean_step_count", step_log.size(), 1);
      btn_n = 1'b1;
      tick(15);

      // Bounce: 3 low / 1 high, ten times, then a solid hold.
      start_scn();
      for (int i = 0; i < 10; i++) begin
         btn_n = 1'b0;
         tick(3);
         btn_n = 1'b1;
         tick(1);
      end
      chk("bounce_no_press", press_log.size(), 0);
      chk("bounce_pressed", pressed_first, -1);
      btn_n = 1'b0;
      tick(12);
      chk("bounce_then_hold_press", press_log.size(), 1);
      btn_n = 1'b1;
      tick(15);

      // Long hold with auto-repeat, released at cycle 60.
      start_scn();
      btn_n = 1'b0;
      tick(60);
      for (int i = 0; i < 7; i++) begin
         if (i < step_log.size()) chk($sformatf("hold_step%0d", i), step_log[i], exp_steps[i]);
         else chk($sformatf("hold_step%0d_missing", i), -1, exp_steps[i]);
      end
      chk("hold_repeat_rise", rep_first, 27);
      btn_n = 1'b1;
      tick(15);
      chk("hold_release_count", rel_log.size(), 1);
      if (rel_log.size() > 0) chk("hold_release_cycle", rel_log[0], 67);
      chk("hold_repeat_fell", repeat_active, 0);

      // Short hold: released at cycle 15, never reaches repeat.
      start_scn();
      btn_n = 1'b0;
      tick(15);
      btn_n = 1'b1;
      tick(15);
      chk("short_step_count", step_log.size(), 1);
      chk("short_release_count", rel_log.size(), 1);
      if (rel_log.size() > 0) chk("short_release_cycle", rel_log[0], 22);
      chk("short_no_repeat", rep_first, -1);

      // Reset while repeating, button still held.
      start_scn();
      btn_n = 1'b0;
      tick(40);
      chk("pre_rst_repeat", repeat_active, 1);
      rst = 1'b1;
      #1;
      chk("rst_pressed", pressed, 0);
      chk("rst_repeat", repeat_active, 0);
      tick(2);
      chk("rst_no_release", rel_log.size(), 0);
      rst = 1'b0;
      start_scn();
      tick(12);
      chk("rst_repress_count", press_log.size(), 1);
      if (press_log.size() > 0) chk("rst_repress_cycle", press_log[0], 7);
      chk("rst_repress_no_release", rel_log.size(), 0);
      btn_n = 1'b1;
      tick(15);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/button_event_gen.md
# button_event_gen

Upstream input-conditioning stage for the push-button counter. It takes one raw, active-low, asynchronous push-button pin and synchronises and debounces it. It then emits single-cycle event pulses in the `real_clk` domain: press, release, and a "step" stream that includes hold-to-auto-repeat. The counter stage consumes `step_pulse` directly as its increment enable, with no edge detection of its own.

## Interface
Parameters:
- `CLK_HZ`, default 12_000_000, frequency of `real_clk` in Hz.
- `DEBOUNCE_MS`, default 20, required stable time before a level change is accepted; must be ≥1.
- `HOLD_MS`, default 500, hold time after a press before auto-repeat starts; 0 disables auto-repeat.
- `REPEAT_MS`, default 100, auto-repeat period; must be ≥1.

Derived constants:
- `DB_CYC = CLK_HZ/1000*DEBOUNCE_MS`
- `HOLD_CYC = CLK_HZ/1000*HOLD_MS`
- `REP_CYC = CLK_HZ/1000*REPEAT_MS`
- Counter widths are `$clog2(max+1)`.

Ports (reset `rst`, asynchronous, active-high; clock `real_clk`):
- `real_clk`, input, 1, system clock.
- `rst`, input, 1, asynchronous active-high reset.
- `btn_n`, input, 1, raw button, active-low, asynchronous to `real_clk`.
- `pressed`, output, 1, debounced level; 1 while the button is held.
- `press_pulse`, output, 1, one-cycle pulse per accepted press.
- `release_pulse`, output, 1, one-cycle pulse per accepted release.
- `step_pulse`, output, 1, one-cycle pulse on each press and on each auto-repeat tick.
- `repeat_active`, output, 1, high while in auto-repeat.

## Operation
- **Synchroniser:** two flops, `s1` and `s2`, sample `~btn_n`. Both reset to 0 (released).
- **Debounce:**
  - `db_cnt` increments each cycle that `s2 != pressed`, and clears to 0 in any cycle where they are equal.
  - When `db_cnt == DB_CYC-1` and `s2` still differs: `pressed <= s2` and `db_cnt <= 0`.
  - Any glitch shorter than `DB_CYC` cycles produces no change.
- **Event FSM** (states RELEASED, HOLD_WAIT, REPEATING), driven by `pressed` and its previous value `pressed_d`:
  - **RELEASED:** on rising `pressed`, assert `press_pulse` and `step_pulse`, load `tmr <= 0`, and go to HOLD_WAIT.
  - **HOLD_WAIT:** `tmr` increments.
    - On falling `pressed`, go to RELEASED with `release_pulse`.
    - Else, if `HOLD_MS != 0` and `tmr == HOLD_CYC-1`, assert `step_pulse`, set `tmr <= 0`, and go to REPEATING.
  - **REPEATING:** `repeat_active = 1`; `tmr` increments.
    - On falling `pressed`, go to RELEASED with `release_pulse`.
    - Else, at `tmr == REP_CYC-1`, assert `step_pulse` and set `tmr <= 0`.
- **Simultaneous release and timer expiry:** release wins. `release_pulse` fires, no `step_pulse`, and the FSM goes to RELEASED.
- `press_pulse` and `release_pulse` are never high in the same cycle. Because of the minimum `DB_CYC` spacing, consecutive accepted edges are at least `DB_CYC` cycles apart.
- **Reset:** all outputs 0, FSM in RELEASED, and all counters, `s1`, `s2` and `pressed_d` at 0.
  - Reset mid-hold or mid-repeat aborts immediately, with no `release_pulse`.
  - If the button is still held when `rst` deasserts, it is treated as a fresh press after the full synchroniser and debounce latency.

## Timing
- All outputs are registered. No combinational path exists from `btn_n` to any output.
- **Press latency:** take cycle 0 as the first `real_clk` edge sampling `btn_n = 0`, with `btn_n` held low from then on.
  - `s2 = 1` after 2 cycles.
  - `pressed = 1` after `2 + DB_CYC` cycles.
  - `press_pulse` and `step_pulse` are high in cycle `2 + DB_CYC + 1`, for exactly one cycle.
- **Release latency:** the same arithmetic applies to `release_pulse`.
- **First auto-repeat step:** `HOLD_CYC` cycles after the press step.
- **Subsequent steps:** every `REP_CYC` cycles.
- `repeat_active` rises in the same cycle as the first repeat step and falls in the same cycle as `release_pulse`.

## Structure
- A shared package `button_pkg` holds the FSM state encoding (2 bits) and a function `ms_to_cycles(clk_hz, ms)`.
- The synchroniser and debounce logic form one natural sub-module, `btn_sync_debounce`, with inputs `real_clk`, `rst`, `raw` and output `level`.
- The FSM and the hold/repeat timer live in `button_event_gen` itself.

## Test plan
All scenarios use `CLK_HZ=1000`, `DEBOUNCE_MS=4`, `HOLD_MS=20`, `REPEAT_MS=5`. Cycle numbers count from the first edge that samples `btn_n = 0`.
- **Reset:** `rst` high with `btn_n` toggling → all outputs stay 0. After release of `rst` with `btn_n = 1` → outputs stay 0.
- **Clean press:** `btn_n` falls at cycle 0 and stays low → `pressed` goes 1 at cycle 6; `press_pulse` and `step_pulse` are high in cycle 7 only.
- **Bounce:** `btn_n` low for 3 cycles, high for 1, repeated 10 times → no pulses and `pressed` stays 0. Then held low → exactly one `press_pulse`.
- **Hold with repeat:** held low for 60 cycles → `step_pulse` at cycles 7, 27, 32, 37, 42, 47, 52; `repeat_active` high from 27 until release is processed.
- **Short hold:** held low for 15 cycles, then released → one `step_pulse` at 7, a `release_pulse` 7 cycles after release, and `repeat_active` never asserts.
- **Reset mid-repeat:** `rst` pulsed at cycle 40 while the button is held → outputs go 0 immediately with no `release_pulse`. After `rst` deasserts → `press_pulse` 7 cycles later.
